value_readout_master: RTL and testbench
=======================================

# value_readout_master

Wishbone master that drains the `value_storage` slave on behalf of a host-side consumer. It performs two operations:
- a direct snapshot, which reads the 32 latest-value registers;
- an indirect stream, which starts, reads and stops the ring buffer at the stream address.

Results are presented on a one-deep valid/ready output port. It sits between the monitor's command decoder and `value_storage`, replacing the hand-rolled bus master used in simulation.

## Interface
Parameters:
- DIRECT_CHANNELS, 32: number of direct registers, read at addresses 0..DIRECT_CHANNELS-1.
- STREAM_ADDR, 16'd32: indirect ring-buffer address.
- MAX_STREAM, 4096: maximum data words per stream before it is aborted.
- ACK_TIMEOUT, 255: cycles to wait for ack before a transfer is abandoned.

Ports:
- wb_clk_i  in  1  clock.
- wb_rst_i  in  1  reset, asynchronous, active-low.
- wbm_cyc_o  out  1  bus cycle.
- wbm_stb_o  out  1  strobe.
- wbm_we_o  out  1  write enable.
- wbm_adr_o  out  16  address.
- wbm_dat_o  out  16  write data.
- wbm_dat_i  in  16  read data.
- wbm_ack_i  in  1  slave acknowledge.
- cmd_snap  in  1  one-cycle pulse: start a direct snapshot.
- cmd_stream  in  1  one-cycle pulse: start an indirect stream.
- busy  out  1  high whenever the FSM is not IDLE.
- out_valid  out  1  output word valid.
- out_ready  in  1  consumer accepts the word.
- out_data  out  16  read word, passed through unmodified.
- out_last  out  1  marks the final word of an operation.
- count_o  out  16  number of words delivered by the last or current operation.
- error  out  1  sticky; set on timeout or overflow; cleared by the next accepted command.

## Operation
**FSM states:** IDLE, SNAP_RD, STR_START, STR_RD, STR_STOP, PUSH_WAIT.

**Command acceptance**
- Commands are accepted only in IDLE.
- If cmd_snap and cmd_stream arrive in the same cycle, snap wins.
- Commands arriving while busy are ignored.
- Accepting a command clears count_o and error.

**Snapshot (SNAP_RD)**
- Performs reads at adr 0..DIRECT_CHANNELS-1 in order.
- Each read word goes to out_data, with out_last set on the final address.
- The next read is issued only after the current word has been accepted.
- Returns to IDLE after the last word is accepted.

**Stream**
- STR_START writes 16'h0000 to STREAM_ADDR.
- STR_RD then performs repeated reads of STREAM_ADDR.
  - A word with bit 15 = 0 is data.
  - A word with bit 15 = 1 is the terminator and is never output.
- Hold buffer:
  - One data word is held internally.
  - The held word is output (out_last = 0) when the next data word returns.
  - When the terminator returns, the held word is output with out_last = 1.
  - A stream with zero data words outputs nothing.
- STR_STOP then writes 16'hFFFF to STREAM_ADDR, after which the FSM returns to IDLE.
- Overflow: if the data count reaches MAX_STREAM without a terminator:
  - error is set;
  - the held word is output with out_last = 1;
  - STR_STOP is still issued.

**Output port**
- count_o increments on each out_valid && out_ready.
- count_o saturates at 16'hFFFF.

**Ack timeout**
- Counted from strobe assertion.
- After ACK_TIMEOUT cycles with no ack:
  - cyc/stb drop;
  - error is set;
  - no stop write is attempted;
  - any held word is discarded;
  - the FSM returns to IDLE.

## Timing
**Reset values:** all outputs are 0, including wbm_adr_o, wbm_dat_o and count_o. Reset is asynchronous, so a reset in the middle of a transfer drops cyc/stb immediately.

**Bus transfers**
- cyc/stb/we/adr/dat are registered and assert on the clock edge after the state requests a transfer.
- They are held stable until ack is sampled high.
- They deassert on that same edge, so ack on cycle N gives stb low on cycle N+1.
- Single-beat transfers only; at least one idle cycle separates consecutive transfers.
- Read data is captured on the edge where ack is sampled.

**Output handshake**
- out_valid rises one cycle after the capturing ack.
- out_data and out_last are held stable while out_valid && !out_ready.
- The transfer completes on the edge where both are high, and out_valid falls that same edge unless a new word is loaded.

**Bus blocking**
- No bus transfer is issued while an output word is pending (PUSH_WAIT).
- Consequently, out_ready held low stalls the bus indefinitely, with no timeout.

**Latency**
- busy rises one cycle after the accepted command.
- With zero-wait ack, a snapshot issues its first strobe on cycle 2.

## Test plan
- **Snapshot:** slave returns 1024+adr with 1-cycle ack, out_ready tied high, pulse cmd_snap → 32 words 0x400..0x41F in order; out_last only on 0x41F; count_o = 32; error = 0.
- **Stream:** slave returns a 3-word buffer 0x405, 0x406, 0x407, then 0x8000.
  - Required bus sequence: write 0x0000 to adr 32; 4 reads; write 0xFFFF.
  - Required output: 3 words, out_last on 0x407; count_o = 3.
- **Backpressure:** out_ready low for 10 cycles mid-snapshot → out_data stable; no strobe during the stall; word sequence unchanged.
- **Timeout:** slave never acks on read 5 → stb drops after ACK_TIMEOUT cycles; error = 1; busy = 0; a following cmd_snap clears error.
- **Overflow:** slave never sets bit 15, MAX_STREAM = 16 → 16 words with last on word 16; error = 1; stop write issued.
- **Async reset and command rules:**
  - Reset asserted mid-transfer → all outputs 0 without waiting for a clock.
  - cmd_snap and cmd_stream pulsed together → snapshot performed.

Source files
------------

// File: rtl/value_readout_master.sv
// Wishbone master that drains value_storage: direct snapshot of the latest-value
// registers, or an indirect ring-buffer stream, delivered over a one-deep valid/ready port.
module value_readout_master #(
  parameter int          DIRECT_CHANNELS = 32,
  parameter logic [15:0] STREAM_ADDR     = 16'd32,
  parameter int          MAX_STREAM      = 4096,
  parameter int          ACK_TIMEOUT     = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [15:0] wbm_adr_o,
  output logic [15:0] wbm_dat_o,
  input  logic [15:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  input  logic        cmd_snap,
  input  logic        cmd_stream,
  output logic        busy,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        out_last,
  output logic [15:0] count_o,
  output logic        error
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_SNAP_RD   = 3'd1;
  localparam logic [2:0] S_STR_START = 3'd2;
  localparam logic [2:0] S_STR_RD    = 3'd3;
  localparam logic [2:0] S_STR_STOP  = 3'd4;
  localparam logic [2:0] S_PUSH_WAIT = 3'd5;

  localparam int          CW        = $clog2(MAX_STREAM + 1);
  localparam logic [CW-1:0] STR_MAX = CW'(MAX_STREAM);
  localparam logic [15:0] SNAP_LAST = 16'(DIRECT_CHANNELS - 1);
  localparam logic [15:0] TMO_LAST  = 16'(ACK_TIMEOUT - 1);

  logic [2:0]    r_state, r_ret;
  logic          r_cyc, r_stb, r_we;
  logic [15:0]   r_adr, r_dat;
  logic [15:0]   r_tmo;
  logic [15:0]   r_idx;
  logic [CW-1:0] r_scnt;
  logic [15:0]   r_hold;
  logic          r_hold_vld;
  logic          r_flush;
  logic          r_out_valid, r_out_last;
  logic [15:0]   r_out_data;
  logic [15:0]   r_count;
  logic          r_error;

  logic          w_xfer_st, w_issue, w_ack, w_tmo, w_accept, w_term, w_str_full;
  logic [CW-1:0] w_scnt_nx;

  assign w_xfer_st  = (r_state == S_SNAP_RD) || (r_state == S_STR_START) ||
                      (r_state == S_STR_RD)  || (r_state == S_STR_STOP);
  assign w_issue    = w_xfer_st && !r_cyc;
  assign w_ack      = r_cyc && wbm_ack_i;
  assign w_tmo      = r_cyc && !wbm_ack_i && (r_tmo == TMO_LAST);
  assign w_accept   = r_out_valid && out_ready;
  assign w_term     = wbm_dat_i[15];
  assign w_scnt_nx  = r_scnt + CW'(1);
  assign w_str_full = (w_scnt_nx == STR_MAX);

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      r_state     <= S_IDLE;
      r_ret       <= S_IDLE;
      r_cyc       <= 1'b0;
      r_stb       <= 1'b0;
      r_we        <= 1'b0;
      r_adr       <= '0;
      r_dat       <= '0;
      r_tmo       <= '0;
      r_idx       <= '0;
      r_scnt      <= '0;
      r_hold      <= '0;
      r_hold_vld  <= 1'b0;
      r_flush     <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_data  <= '0;
      r_count     <= '0;
      r_error     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_out_valid <= 1'b0;
        if (r_count != 16'hFFFF) r_count <= r_count + 16'd1;
      end

      // Bus side: launch one beat per request, hold until ack or timeout.
      if (w_issue) begin
        r_cyc <= 1'b1;
        r_stb <= 1'b1;
        r_tmo <= '0;
        case (r_state)
          S_SNAP_RD:   begin r_we <= 1'b0; r_adr <= r_idx;       r_dat <= 16'h0000; end
          S_STR_START: begin r_we <= 1'b1; r_adr <= STREAM_ADDR; r_dat <= 16'h0000; end
          S_STR_RD:    begin r_we <= 1'b0; r_adr <= STREAM_ADDR; r_dat <= 16'h0000; end
          default:     begin r_we <= 1'b1; r_adr <= STREAM_ADDR; r_dat <= 16'hFFFF; end
        endcase
      end else if (r_cyc) begin
        if (wbm_ack_i || w_tmo) begin
          r_cyc <= 1'b0;
          r_stb <= 1'b0;
          r_we  <= 1'b0;
        end else begin
          r_tmo <= r_tmo + 16'd1;
        end
      end

      case (r_state)
        S_IDLE: begin
          if (cmd_snap) begin
            r_state <= S_SNAP_RD;
            r_idx   <= '0;
            r_count <= '0;
            r_error <= 1'b0;
          end else if (cmd_stream) begin
            r_state    <= S_STR_START;
            r_scnt     <= '0;
            r_hold_vld <= 1'b0;
            r_flush    <= 1'b0;
            r_count    <= '0;
            r_error    <= 1'b0;
          end
        end

        S_SNAP_RD: begin
          if (w_ack) begin
            r_out_valid <= 1'b1;
            r_out_data  <= wbm_dat_i;
            r_out_last  <= (r_idx == SNAP_LAST);
            r_ret       <= (r_idx == SNAP_LAST) ? S_IDLE : S_SNAP_RD;
            r_idx       <= r_idx + 16'd1;
            r_state     <= S_PUSH_WAIT;
          end else if (w_tmo) begin
            r_error <= 1'b1;
            r_state <= S_IDLE;
          end
        end

        S_STR_START: begin
          if (w_ack) begin
            r_state <= S_STR_RD;
          end else if (w_tmo) begin
            r_error <= 1'b1;
            r_state <= S_IDLE;
          end
        end

        // One word is always held back so the final data word can carry out_last.
        S_STR_RD: begin
          if (w_ack) begin
            if (w_term) begin
              if (r_hold_vld) begin
                r_out_valid <= 1'b1;
                r_out_data  <= r_hold;
                r_out_last  <= 1'b1;
                r_hold_vld  <= 1'b0;
                r_ret       <= S_STR_STOP;
                r_state     <= S_PUSH_WAIT;
              end else begin
                r_state <= S_STR_STOP;
              end
            end else begin
              r_scnt <= w_scnt_nx;
              if (w_str_full) r_error <= 1'b1;
              if (r_hold_vld) begin
                r_out_valid <= 1'b1;
                r_out_data  <= r_hold;
                r_out_last  <= 1'b0;
                r_hold      <= wbm_dat_i;
                r_flush     <= w_str_full;
                r_ret       <= w_str_full ? S_STR_STOP : S_STR_RD;
                r_state     <= S_PUSH_WAIT;
              end else if (w_str_full) begin
                r_out_valid <= 1'b1;
                r_out_data  <= wbm_dat_i;
                r_out_last  <= 1'b1;
                r_ret       <= S_STR_STOP;
                r_state     <= S_PUSH_WAIT;
              end else begin
                r_hold     <= wbm_dat_i;
                r_hold_vld <= 1'b1;
              end
            end
          end else if (w_tmo) begin
            r_error    <= 1'b1;
            r_hold_vld <= 1'b0;
            r_state    <= S_IDLE;
          end
        end

        S_STR_STOP: begin
          if (w_ack) begin
            r_state <= S_IDLE;
          end else if (w_tmo) begin
            r_error <= 1'b1;
            r_state <= S_IDLE;
          end
        end

        // On overflow the held word is pushed straight behind the accepted one.
        S_PUSH_WAIT: begin
          if (w_accept) begin
            if (r_flush) begin
              r_out_valid <= 1'b1;
              r_out_data  <= r_hold;
              r_out_last  <= 1'b1;
              r_hold_vld  <= 1'b0;
              r_flush     <= 1'b0;
            end else begin
              r_state <= r_ret;
            end
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign wbm_cyc_o = r_cyc;
  assign wbm_stb_o = r_stb;
  assign wbm_we_o  = r_we;
  assign wbm_adr_o = r_adr;
  assign wbm_dat_o = r_dat;
  assign busy      = (r_state != S_IDLE);
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign count_o   = r_count;
  assign error     = r_error;

endmodule

// File: tb/tb_value_readout_master.sv
// Bench for value_readout_master: behavioural Wishbone slave, randomized consumer,
// and a queue-based reference of what each snapshot/stream must deliver.
module tb_value_readout_master;

  localparam int          DC   = 32;
  localparam logic [15:0] SA   = 16'd32;
  localparam int          MAXS = 16;
  localparam int          TMO  = 40;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cyc, stb, we, ack;
  logic [15:0] adr, dat_o, dat_i;
  logic        cmd_snap, cmd_stream;
  logic        busy, out_valid, out_ready, out_last, error;
  logic [15:0] out_data, count_o;

  value_readout_master #(
    .DIRECT_CHANNELS(DC), .STREAM_ADDR(SA), .MAX_STREAM(MAXS), .ACK_TIMEOUT(TMO)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(rst_n),
    .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_adr_o(adr), .wbm_dat_o(dat_o),
    .wbm_dat_i(dat_i), .wbm_ack_i(ack),
    .cmd_snap(cmd_snap), .cmd_stream(cmd_stream), .busy(busy),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .count_o(count_o), .error(error)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;

  logic [15:0] mem [0:31];
  logic [15:0] sq  [0:31];
  int          sq_len;
  int          rdy_mode;
  bit          ack_rand, hang_en;
  logic [15:0] hang_adr;

  // written only by the slave/monitor process
  logic [32:0] blog[$];
  logic [16:0] got[$];
  int          viol_stable = 0, viol_stb = 0;
  int          stb_run = 0, last_run = 0, sptr = 0, wcnt = 0, dly = 0;
  bit          in_x = 0, pv = 0, pr = 0, pl = 0;
  logic [15:0] pd = '0;

  // written only by the initial block
  logic [16:0] exp_w[$];
  logic [32:0] exp_l[$];
  bit          exp_err;
  int          gb, lb;

  initial begin ack = 1'b0; dat_i = '0; out_ready = 1'b0; end

  always @(negedge clk) begin
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(0, 3) != 0);
      default: out_ready = 1'b0;
    endcase
    if (rst_n && pv && !pr && (!out_valid || out_data !== pd || out_last !== pl)) viol_stable++;
    if (out_valid && stb) viol_stb++;
    if (out_valid && out_ready) got.push_back({out_last, out_data});
    pv = out_valid; pr = out_ready; pd = out_data; pl = out_last;

    ack = 1'b0;
    if (cyc && stb) begin
      stb_run++;
      if (!in_x) begin in_x = 1; wcnt = 0; dly = ack_rand ? int'($urandom_range(0, 2)) : 0; end
      if (!(hang_en && !we && adr == hang_adr)) begin
        if (wcnt >= dly) begin
          ack  = 1'b1;
          in_x = 0;
          if (we) begin
            blog.push_back({1'b1, adr, dat_o});
            if (adr == SA && dat_o == 16'h0000) sptr = 0;
            dat_i = '0;
          end else begin
            blog.push_back({1'b0, adr, 16'h0000});
            if (adr == SA) begin
              dat_i = (sptr < sq_len) ? sq[sptr] : 16'h8000;
              sptr++;
            end else begin
              dat_i = (adr < 16'd32) ? mem[adr[4:0]] : 16'hDEAD;
            end
          end
        end else begin
          wcnt++;
        end
      end
    end else begin
      if (stb_run != 0) last_run = stb_run;
      stb_run = 0;
      in_x = 0;
    end
  end

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse(bit s, bit t);
    @(negedge clk); cmd_snap = s; cmd_stream = t;
    @(negedge clk); cmd_snap = 1'b0; cmd_stream = 1'b0;
  endtask

  task automatic start_op();
    gb = got.size();
    lb = blog.size();
  endtask

  // Reference: a snapshot delivers mem[0..upto-1]; cut short means a timeout.
  task automatic exp_snap(int upto);
    exp_w.delete(); exp_l.delete();
    for (int i = 0; i < upto; i++) begin
      exp_w.push_back({(i == DC - 1), mem[i]});
      exp_l.push_back({1'b0, 16'(i), 16'h0000});
    end
    exp_err = (upto < DC);
  endtask

  // Reference: data words up to the terminator, capped at MAXS.
  task automatic exp_stream();
    logic [15:0] w[$];
    int nr;
    bit ovf;
    ovf = 0;
    exp_w.delete(); exp_l.delete();
    for (int i = 0; i < sq_len; i++) begin
      if (sq[i][15]) break;
      w.push_back(sq[i]);
      if (w.size() == MAXS) begin ovf = 1; break; end
    end
    nr = ovf ? MAXS : w.size() + 1;
    foreach (w[i]) exp_w.push_back({(i == w.size() - 1), w[i]});
    exp_l.push_back({1'b1, SA, 16'h0000});
    repeat (nr) exp_l.push_back({1'b0, SA, 16'h0000});
    exp_l.push_back({1'b1, SA, 16'hFFFF});
    exp_err = ovf;
  endtask

  task automatic finish_op(string tag);
    int n;
    n = 0;
    while (busy && n < 5000) begin @(negedge clk); n++; end
    check({tag, "_end"}, 64'(n < 5000), 64'd1);
    repeat (2) @(negedge clk);
    check({tag, "_nout"}, 64'(got.size() - gb), 64'(exp_w.size()));
    for (int i = 0; i < exp_w.size(); i++)
      if (gb + i < got.size()) check({tag, "_word"}, 64'(got[gb + i]), 64'(exp_w[i]));
    check({tag, "_count"}, 64'(count_o), 64'(exp_w.size()));
    check({tag, "_error"}, 64'(error), 64'(exp_err));
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_nbus"}, 64'(blog.size() - lb), 64'(exp_l.size()));
    for (int i = 0; i < exp_l.size(); i++)
      if (lb + i < blog.size()) check({tag, "_bus"}, 64'(blog[lb + i]), 64'(exp_l[i]));
    check({tag, "_stable"}, 64'(viol_stable), 64'd0);
    check({tag, "_nostb"}, 64'(viol_stb), 64'd0);
  endtask

  initial begin
    int n, k;
    rst_n = 1'b0; cmd_snap = 1'b0; cmd_stream = 1'b0;
    rdy_mode = 0; ack_rand = 0; hang_en = 0; hang_adr = '0; sq_len = 0;
    for (int i = 0; i < 32; i++) begin mem[i] = 16'(1024 + i); sq[i] = '0; end

    #3;
    check("rst_bus", 64'({cyc, stb, we, adr, dat_o}), 64'd0);
    check("rst_out", 64'({busy, out_valid, out_data, out_last, count_o, error}), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_bus", 64'({cyc, stb, we, adr, dat_o}), 64'd0);

    // plan snapshot 0x400+adr, zero-wait ack, latency
    start_op();
    pulse(1, 0);
    check("lat_busy", 64'(busy), 64'd1);
    check("lat_stb0", 64'(stb), 64'd0);
    @(negedge clk);
    check("lat_stb1", 64'(stb), 64'd1);
    exp_snap(DC);
    finish_op("snap_plan");

    // random data, random waits/backpressure, stream command ignored while busy
    for (int i = 0; i < 32; i++) mem[i] = 16'($urandom);
    ack_rand = 1; rdy_mode = 1;
    start_op();
    pulse(1, 0);
    repeat (20) @(negedge clk);
    pulse(0, 1);
    exp_snap(DC);
    finish_op("snap_rand");

    // plan stream
    ack_rand = 0; rdy_mode = 0;
    sq[0] = 16'h0405; sq[1] = 16'h0406; sq[2] = 16'h0407; sq[3] = 16'h8000; sq_len = 4;
    start_op();
    pulse(0, 1);
    exp_stream();
    finish_op("str_plan");

    // random streams including an empty one
    ack_rand = 1; rdy_mode = 1;
    for (int t = 0; t < 4; t++) begin
      k = (t == 0) ? 0 : int'($urandom_range(1, 12));
      for (int i = 0; i < k; i++) sq[i] = 16'($urandom) & 16'h7FFF;
      sq[k] = 16'($urandom) | 16'h8000;
      sq_len = k + 1;
      start_op();
      pulse(0, 1);
      exp_stream();
      finish_op("str_rand");
    end

    // backpressure stall mid-snapshot
    ack_rand = 0; rdy_mode = 0;
    start_op();
    pulse(1, 0);
    n = 0;
    while (got.size() - gb < 10 && n < 500) begin @(negedge clk); n++; end
    rdy_mode = 2;
    @(negedge clk);
    n = 0;
    while (!out_valid && n < 50) begin @(negedge clk); n++; end
    k = got.size() - gb;
    check("bp_data0", 64'(out_data), 64'(mem[k]));
    repeat (10) @(negedge clk);
    check("bp_valid", 64'(out_valid), 64'd1);
    check("bp_data10", 64'(out_data), 64'(mem[k]));
    check("bp_nostb", 64'(stb), 64'd0);
    check("bp_count", 64'(count_o), 64'(k));
    rdy_mode = 0;
    exp_snap(DC);
    finish_op("bp");

    // ack timeout on read 5, then a new snapshot clears error
    for (int i = 0; i < 32; i++) mem[i] = 16'($urandom);
    hang_en = 1; hang_adr = 16'd5; rdy_mode = 1;
    start_op();
    pulse(1, 0);
    exp_snap(5);
    finish_op("tmo");
    check("tmo_stb_cycles", 64'(last_run), 64'(TMO));
    hang_en = 0;
    start_op();
    pulse(1, 0);
    check("tmo_err_clr", 64'(error), 64'd0);
    exp_snap(DC);
    finish_op("after_tmo");

    // overflow: no terminator in sight
    for (int i = 0; i < 20; i++) sq[i] = 16'($urandom) & 16'h7FFF;
    sq_len = 20;
    start_op();
    pulse(0, 1);
    exp_stream();
    finish_op("ovf");

    // both commands together: snapshot wins
    start_op();
    pulse(1, 1);
    exp_snap(DC);
    finish_op("both");

    // asynchronous reset mid-transfer
    ack_rand = 0; rdy_mode = 0; hang_en = 1; hang_adr = 16'd3;
    pulse(1, 0);
    n = 0;
    while (!(stb && adr == 16'd3) && n < 100) begin @(negedge clk); n++; end
    check("arst_reach", 64'(stb), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_bus", 64'({cyc, stb, we, adr, dat_o}), 64'd0);
    check("arst_out", 64'({busy, out_valid, out_data, out_last, count_o, error}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1; hang_en = 0;
    @(negedge clk);
    check("arst_idle", 64'(busy), 64'd0);

    start_op();
    pulse(1, 0);
    exp_snap(DC);
    finish_op("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
